// File: rtl/if_pkg.sv
// ----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch prefetch unit:
//   - default parameter values (address width, queue depth, reset PC)
//   - the queue entry layout {pc, inst} for the default address width
//   - pointer / counter widths derived from the default queue depth
// ----------------------------------------------------------------------------
package if_pkg;

    localparam int unsigned XLEN_DEFAULT     = 32;
    localparam int unsigned DEPTH_DEFAULT    = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Pointers carry one extra wrap bit, so a DEPTH-entry queue needs
    // clog2(DEPTH)+1 bits, which equals clog2(DEPTH+1) for powers of two.
    localparam int unsigned PTR_W_DEFAULT = $clog2(DEPTH_DEFAULT);
    localparam int unsigned CNT_W_DEFAULT = $clog2(DEPTH_DEFAULT + 1);

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [31:0]             inst;
    } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// ----------------------------------------------------------------------------
// prefetch_fifo
// Circular-buffer queue holding fetched {pc, inst} entries.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push, push_data write tail (ignored when full)
//   pop             advance head (ignored when empty)
//   flush           empty the queue; wins over push and pop
//   pop_data        head entry
//   full, empty     status
//   count           number of valid entries
// ----------------------------------------------------------------------------
module prefetch_fifo
    import if_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN_DEFAULT + 32,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Full when the index bits match but the wrap bits differ.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        count    = wr_ptr_q - rd_ptr_q;
        pop_data = mem_q[rd_ptr_q[PTR_W-1:0]];
        do_push  = push && !full;
        do_pop   = pop && !empty;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// ----------------------------------------------------------------------------
// if_prefetch_unit
// Instruction prefetcher: issues word-aligned fetches, queues in-order
// responses, and hands them to the IF/ID register. A redirect flushes the
// queue, restarts fetching at the new target and drops every response still
// in flight.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   redirect_valid, redirect_pc   taken branch/jump from ID
//   imem_req, imem_addr, imem_gnt instruction memory request channel
//   imem_rvalid, imem_rdata       in-order response channel
//   inst_valid, inst_ready        handshake toward IF/ID
//   inst_out, pc_out              head instruction and its PC
//   occupancy                     valid queue entries
// ----------------------------------------------------------------------------
module if_prefetch_unit
    import if_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter int unsigned     DEPTH    = DEPTH_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [31:0]                imem_rdata,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [31:0]                inst_out,
    output logic [XLEN-1:0]            pc_out,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENTRY_W = XLEN + 32;

    logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]    resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   discard_q, discard_d;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     credit_used;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic               req_fire;
    logic               resp_fire;
    logic               push;
    logic               pop;
    logic               redirect_target_unused;
    logic [XLEN-1:0]    redirect_aligned;

    // Responses arrive in order, so the PC of the next kept response is just
    // a second counter that follows fetch_pc; no per-request PC storage needed.
    // A request is only issued if a queue slot is reserved for its response,
    // counting both queued entries and requests still in flight.
    always_comb begin
        redirect_aligned       = {redirect_pc[XLEN-1:2], 2'b00};
        redirect_target_unused = ^redirect_pc[1:0];
        credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
        imem_req    = rst && (credit_used < (CNT_W+1)'(DEPTH));
        imem_addr   = fetch_pc_q;
        req_fire    = imem_req && imem_gnt;
        resp_fire   = imem_rvalid && (outstanding_q != '0);
        push        = resp_fire && (discard_q == '0) && !redirect_valid;
        pop         = !fifo_empty && inst_ready && !redirect_valid;
        push_data   = {resp_pc_q, imem_rdata};

        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(resp_fire);
        discard_d     = discard_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;

        if (resp_fire && (discard_q != '0)) begin
            discard_d = discard_q - CNT_W'(1);
        end
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        if (push) begin
            resp_pc_d = resp_pc_q + XLEN'(4);
        end
        // Everything still in flight after this cycle (including a request
        // granted right now) belongs to the old path and must be dropped.
        if (redirect_valid) begin
            fetch_pc_d = redirect_aligned;
            resp_pc_d  = redirect_aligned;
            discard_d  = outstanding_d;
        end

        inst_valid = !fifo_empty;
        pc_out     = head_data[ENTRY_W-1:32];
        inst_out   = head_data[31:0];
        occupancy  = fifo_count;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            // A response with nothing in flight is ignored but flagged.
            assert (!(imem_rvalid && (outstanding_q == '0)))
                else $error("if_prefetch_unit: imem_rvalid with no outstanding request");
        end
    end

    prefetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .pop_data  (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // The low redirect bits are dropped by alignment and the full flag is
    // never needed because credits prevent overflow.
    logic unused_ok;
    assign unused_ok = redirect_target_unused ^ fifo_full;

endmodule

// File: doc/if_prefetch_unit.md
IF_PREFETCH_UNIT -- requirements
Module: if_prefetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC/address width.
REQ-002 SHALL have parameter DEPTH, default 4: prefetch queue entries, power of two, >=2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port redirect_valid  in  1  branch/jump taken in ID, flush and refetch.
REQ-007 SHALL have port redirect_pc  in  XLEN  new fetch target.
REQ-008 SHALL have port imem_req  out  1  fetch request to instruction memory.
REQ-009 SHALL have port imem_addr  out  XLEN  word-aligned fetch address.
REQ-010 SHALL have port imem_gnt  in  1  request accepted this cycle.
REQ-011 SHALL have port imem_rvalid  in  1  in-order response valid.
REQ-012 SHALL have port imem_rdata  in  32  fetched instruction.
REQ-013 SHALL have port inst_valid  out  1  queue head valid toward IF/ID register.
REQ-014 SHALL have port inst_ready  in  1  IF/ID register accepts (low = data stall).
REQ-015 SHALL have port inst_out  out  32  head instruction.
REQ-016 SHALL have port pc_out  out  XLEN  head instruction's PC.
REQ-017 SHALL have port occupancy  out  clog2(DEPTH+1)  valid queue entries.

Function
REQ-018 SHALL drive imem_req high only when queued entries + outstanding (granted, not yet returned) requests < DEPTH, so every response has a reserved slot.
REQ-019 SHALL hold imem_addr stable while imem_req is high and imem_gnt low, except on redirect.
REQ-020 SHALL advance fetch_pc by 4 on each req&&gnt; addition wraps modulo 2^XLEN.
REQ-021 SHALL write {fetch-time PC, imem_rdata} into queue tail on imem_rvalid with discard count 0; entry visible on inst_valid the next cycle (no bypass).
REQ-022 SHALL pop head on inst_valid&&inst_ready; push and pop in same cycle leave occupancy unchanged.
REQ-023 SHALL keep inst_out/pc_out stable while inst_valid high and inst_ready low.
REQ-024 On redirect_valid in cycle t SHALL: empty queue, set fetch_pc = {redirect_pc[XLEN-1:2],2'b00}, load discard count with outstanding requests (including one granted in t), drive inst_valid low in t+1, and issue imem_req for the new PC no earlier than t+1.
REQ-025 SHALL drop responses while discard count > 0, decrementing it per response; redirect overrides push, pop and grant in the same cycle.
REQ-026 SHALL ignore imem_rvalid with no outstanding request (simulation assertion flags it).
REQ-027 Back-to-back redirects SHALL each restart from the latest redirect_pc; discard count accumulates correctly.

Reset
REQ-028 While rst low: imem_req=0, inst_valid=0, occupancy=0, outstanding=0, discard=0, fetch_pc=RESET_PC, queue pointers 0.
REQ-029 First imem_req (addr RESET_PC) SHALL assert in first cycle after rst deasserts; reset mid-transaction abandons in-flight requests.

Structure
REQ-030 Shared package if_pkg SHALL hold RESET_PC default, entry typedef {pc, inst}, and clog2-derived pointer/counter widths.
REQ-031 Queue SHALL be a separate circular-buffer sub-module prefetch_fifo (push/pop/flush, full/empty, wrap-around pointers with extra wrap bit).
REQ-032 Credit counter, discard counter, and fetch_pc SHALL live in if_prefetch_unit.

Verification
REQ-033 Reset release, gnt=1, 1-cycle rvalid, inst_ready=1 -> addrs 0x0,0x4,0x8... ; pc_out follows 0x0,0x4,0x8 one per cycle after pipeline fill.
REQ-034 inst_ready=0 for 10 cycles, DEPTH=4 -> occupancy saturates at 4, imem_req drops, no overflow; release -> 4 entries drain in order.
REQ-035 Two requests outstanding, redirect to 0x100 -> both stale responses dropped, next pc_out = 0x100, then 0x104.
REQ-036 Redirect to 0x203 -> imem_addr = 0x200.
REQ-037 RESET_PC=0xFFFF_FFFC -> second request addr 0x0000_0000.
REQ-038 rst asserted with queue 3 full and 2 outstanding -> outputs reset immediately; post-reset late rvalids ignored, first pc_out = RESET_PC.
